// File: rtl/matmul_seq.sv
// matmul_seq: sequential floating-point matrix multiplier, O = A x B.
// A is H x C, B is C x W, O is H x W; all row-major with element (0,0)
// in the MSBs. One mul_float and one add_float core are time-shared.
// Only one operation is in flight at a time.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle job request, honoured only in IDLE
//   a, b                  operand matrices, captured on an accepted start
//   o                     registered result matrix
//   busy, done            busy while a job runs; done pulses once at the end
//   nan/overflow/underflow sticky per-job exception flags
// The file also holds the two arithmetic cores, mul_float and add_float.
// They flush denormals to zero and round to nearest-even. Each core
// registers its result on start and raises done LAT cycles later.

module mul_float #(
    parameter int FLOAT_WIDTH = 32,
    parameter int LAT         = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [FLOAT_WIDTH-1:0] op1,
    input  logic [FLOAT_WIDTH-1:0] op2,
    output logic [FLOAT_WIDTH-1:0] result,
    output logic                   done,
    output logic                   nan,
    output logic                   overflow,
    output logic                   underflow
);
    localparam int FW   = FLOAT_WIDTH;
    localparam int EW   = (FW == 64) ? 11 : (FW == 16) ? 5 : 8;
    localparam int MW   = FW - EW - 1;
    localparam int PW   = 2 * MW + 2;
    localparam int BIAS = (1 << (EW - 1)) - 1;
    localparam int EMAX = (1 << EW) - 1;
    localparam logic [FW-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

    logic          sa, sb, sr, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [EW-1:0] ea, eb;
    logic [MW-1:0] ma, mb, mant, mr;
    logic [PW-1:0] prod;
    logic [PW-2:0] norm;    // fraction bits only, hidden bit removed
    logic          g, st, rnd, cy, nan_c, ovf_c, unf_c;
    logic [FW-1:0] res_c;
    int            er;
    logic [LAT-1:0] vld_pipe;

    always_comb begin
        {sa, ea, ma} = op1;
        {sb, eb, mb} = op2;
        sr     = sa ^ sb;
        a_nan  = (&ea) & (|ma);
        b_nan  = (&eb) & (|mb);
        a_inf  = (&ea) & ~(|ma);
        b_inf  = (&eb) & ~(|mb);
        a_zero = ~(|ea);
        b_zero = ~(|eb);
        prod   = {1'b1, ma} * {1'b1, mb};
        er     = int'(ea) + int'(eb) - BIAS;
        if (prod[PW-1]) begin
            norm = prod[PW-2:0];
            er   = er + 1;
        end else begin
            norm = {prod[PW-3:0], 1'b0};
        end
        mant = norm[2*MW -: MW];
        g    = norm[MW-1+1-1+1-1];
        g    = norm[MW];
        st   = |norm[MW-1:0];
        rnd  = g & (st | mant[0]);
        {cy, mr} = {1'b0, mant} + {{MW{1'b0}}, rnd};
        if (cy) er = er + 1;

        nan_c = 1'b0;
        ovf_c = 1'b0;
        unf_c = 1'b0;
        if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)) begin
            nan_c = 1'b1;
            res_c = QNAN;
        end else if (a_inf | b_inf) begin
            res_c = {sr, {EW{1'b1}}, {MW{1'b0}}};
        end else if (a_zero | b_zero) begin
            res_c = {sr, {(FW-1){1'b0}}};
        end else if (er >= EMAX) begin
            ovf_c = 1'b1;
            res_c = {sr, {EW{1'b1}}, {MW{1'b0}}};
        end else if (er <= 0) begin
            unf_c = 1'b1;
            res_c = {sr, {(FW-1){1'b0}}};
        end else begin
            res_c = {sr, er[EW-1:0], mr};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            result    <= '0;
            nan       <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            vld_pipe <= (vld_pipe << 1) | LAT'(start);
            if (start) begin
                result    <= res_c;
                nan       <= nan_c;
                overflow  <= ovf_c;
                underflow <= unf_c;
            end
        end
    end

    assign done = vld_pipe[LAT-1];
endmodule

module add_float #(
    parameter int FLOAT_WIDTH = 32,
    parameter int LAT         = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   sub,
    input  logic [FLOAT_WIDTH-1:0] op1,
    input  logic [FLOAT_WIDTH-1:0] op2,
    output logic [FLOAT_WIDTH-1:0] result,
    output logic                   done,
    output logic                   nan,
    output logic                   overflow,
    output logic                   underflow
);
    localparam int FW   = FLOAT_WIDTH;
    localparam int EW   = (FW == 64) ? 11 : (FW == 16) ? 5 : 8;
    localparam int MW   = FW - EW - 1;
    localparam int XW   = MW + 4;    // hidden + fraction + guard/round/sticky
    localparam int EMAX = (1 << EW) - 1;
    localparam logic [FW-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

    logic          sa, sbe, sx, sy, swap, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [EW-1:0] ea, eb, ex, ey;
    logic [MW-1:0] ma, mb, mx, my, mant, mr;
    logic [XW-1:0] xm, ym, ys, t;
    logic [XW:0]   sum;
    logic          g, st, rnd, cy, nan_c, ovf_c, unf_c;
    logic [FW-1:0] res_c;
    int            d, lz, er;
    logic [LAT-1:0] vld_pipe;

    always_comb begin
        sa       = op1[FW-1];
        {ea, ma} = op1[FW-2:0];
        sbe      = op2[FW-1] ^ sub;
        {eb, mb} = op2[FW-2:0];
        a_nan  = (&ea) & (|ma);
        b_nan  = (&eb) & (|mb);
        a_inf  = (&ea) & ~(|ma);
        b_inf  = (&eb) & ~(|mb);
        a_zero = ~(|ea);
        b_zero = ~(|eb);
        // x is the larger magnitude, so the aligned difference is never negative
        swap = op2[FW-2:0] > op1[FW-2:0];
        {sx, ex, mx} = swap ? {sbe, eb, mb} : {sa, ea, ma};
        {sy, ey, my} = swap ? {sa, ea, ma} : {sbe, eb, mb};
        d  = int'(ex) - int'(ey);
        xm = {1'b1, mx, 3'b000};
        ym = {1'b1, my, 3'b000};
        if (d >= XW) ys = XW'(1);
        else         ys = (ym >> d) | XW'(|(ym & ~({XW{1'b1}} << d)));
        sum = (sx == sy) ? ({1'b0, xm} + {1'b0, ys}) : ({1'b0, xm} - {1'b0, ys});
        lz = XW;
        for (int n = 0; n < XW; n++) if (sum[n]) lz = XW - 1 - n;
        if (sum[XW]) begin
            t  = {sum[XW:2], sum[1] | sum[0]};
            er = int'(ex) + 1;
        end else begin
            t  = sum[XW-1:0] << lz;
            er = int'(ex) - lz;
        end
        mant = t[XW-2:3];
        g    = t[2];
        st   = |t[1:0];
        rnd  = g & (st | mant[0]);
        {cy, mr} = {1'b0, mant} + {{MW{1'b0}}, rnd};
        if (cy) er = er + 1;

        nan_c = 1'b0;
        ovf_c = 1'b0;
        unf_c = 1'b0;
        if (a_nan | b_nan | (a_inf & b_inf & (sa != sbe))) begin
            nan_c = 1'b1;
            res_c = QNAN;
        end else if (a_inf)            res_c = op1;
        else if (b_inf)                res_c = {sbe, eb, mb};
        else if (a_zero & b_zero)      res_c = {sa & sbe, {(FW-1){1'b0}}};
        else if (a_zero)               res_c = {sbe, eb, mb};
        else if (b_zero)               res_c = op1;
        else if (!t[XW-1])             res_c = '0;    // exact cancellation
        else if (er >= EMAX) begin
            ovf_c = 1'b1;
            res_c = {sx, {EW{1'b1}}, {MW{1'b0}}};
        end else if (er <= 0) begin
            unf_c = 1'b1;
            res_c = {sx, {(FW-1){1'b0}}};
        end else begin
            res_c = {sx, er[EW-1:0], mr};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            result    <= '0;
            nan       <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            vld_pipe <= (vld_pipe << 1) | LAT'(start);
            if (start) begin
                result    <= res_c;
                nan       <= nan_c;
                overflow  <= ovf_c;
                underflow <= unf_c;
            end
        end
    end

    assign done = vld_pipe[LAT-1];
endmodule

module matmul_seq #(
    parameter int S        = 32,
    parameter int H        = 2,
    parameter int W        = 2,
    parameter int C        = 2,
    parameter int CORE_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [S*H*C-1:0] a,
    input  logic [S*C*W-1:0] b,
    output logic [S*H*W-1:0] o,
    output logic             busy,
    output logic             done,
    output logic             nan,
    output logic             overflow,
    output logic             underflow
);
    localparam int IW = (H > 1) ? $clog2(H) : 1;
    localparam int JW = (W > 1) ? $clog2(W) : 1;
    localparam int KW = (C > 1) ? $clog2(C) : 1;

    typedef enum logic [2:0] {IDLE, MUL_GO, MUL_WAIT, ADD_GO, ADD_WAIT, NEXT, DONE} state_t;

    state_t           state_q, state_d;
    logic [S*H*C-1:0] a_q, a_d;
    logic [S*C*W-1:0] b_q, b_d;
    logic [S*H*W-1:0] o_q, o_d;
    logic [IW-1:0]    i_q, i_d;
    logic [JW-1:0]    j_q, j_d;
    logic [KW-1:0]    k_q, k_d;
    logic [S-1:0]     acc_q, acc_d, p_q, p_d;
    logic             nan_q, nan_d, ovf_q, ovf_d, unf_q, unf_d;

    logic             mul_go, add_go, mul_done, add_done;
    logic             mul_nan, mul_ovf, mul_unf, add_nan, add_ovf, add_unf;
    logic [S-1:0]     mul_op1, mul_op2, mul_res, add_res;

    always_comb begin
        mul_op1 = a_q[S*(H*C-1-(int'(i_q)*C+int'(k_q))) +: S];
        mul_op2 = b_q[S*(C*W-1-(int'(k_q)*W+int'(j_q))) +: S];
    end

    mul_float #(.FLOAT_WIDTH(S), .LAT(CORE_LAT)) u_mul (
        .clk(clk), .rst_n(rst_n), .start(mul_go), .op1(mul_op1), .op2(mul_op2),
        .result(mul_res), .done(mul_done), .nan(mul_nan), .overflow(mul_ovf),
        .underflow(mul_unf)
    );

    add_float #(.FLOAT_WIDTH(S), .LAT(CORE_LAT)) u_add (
        .clk(clk), .rst_n(rst_n), .start(add_go), .sub(1'b0), .op1(acc_q), .op2(p_q),
        .result(add_res), .done(add_done), .nan(add_nan), .overflow(add_ovf),
        .underflow(add_unf)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        o_d     = o_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        acc_d   = acc_q;
        p_d     = p_q;
        nan_d   = nan_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        mul_go  = 1'b0;
        add_go  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                a_d     = a;
                b_d     = b;
                nan_d   = 1'b0;
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
                i_d     = '0;
                j_d     = '0;
                k_d     = '0;
                state_d = MUL_GO;
            end
            MUL_GO: begin
                mul_go  = 1'b1;
                state_d = MUL_WAIT;
            end
            // The core's done is only looked at from the cycle after its start.
            MUL_WAIT: if (mul_done) begin
                p_d   = mul_res;
                nan_d = nan_q | mul_nan;
                ovf_d = ovf_q | mul_ovf;
                unf_d = unf_q | mul_unf;
                if (k_q == '0) begin
                    acc_d   = mul_res;    // first product seeds the sum, no +0 add
                    state_d = NEXT;
                end else begin
                    state_d = ADD_GO;
                end
            end
            ADD_GO: begin
                add_go  = 1'b1;
                state_d = ADD_WAIT;
            end
            ADD_WAIT: if (add_done) begin
                acc_d   = add_res;
                nan_d   = nan_q | add_nan;
                ovf_d   = ovf_q | add_ovf;
                unf_d   = unf_q | add_unf;
                state_d = NEXT;
            end
            NEXT: begin
                if (k_q != KW'(C-1)) begin
                    k_d     = k_q + 1'b1;
                    state_d = MUL_GO;
                end else begin
                    o_d[S*(H*W-1-(int'(i_q)*W+int'(j_q))) +: S] = acc_q;
                    k_d     = '0;
                    state_d = MUL_GO;
                    if (j_q == JW'(W-1)) begin
                        j_d = '0;
                        if (i_q == IW'(H-1)) begin
                            i_d     = '0;
                            state_d = DONE;
                        end else begin
                            i_d = i_q + 1'b1;
                        end
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;    // start in this cycle is deliberately dropped
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            o_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            p_q     <= '0;
            nan_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            o_q     <= o_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            nan_q   <= nan_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign o         = o_q;
    assign busy      = (state_q != IDLE) && (state_q != DONE);
    assign done      = (state_q == DONE);
    assign nan       = nan_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
endmodule
